// File: rtl/pll_conf_ctrl.sv
// PLL reconfiguration controller: shadow divider words, apply/lock handshake.
// Optional macro PLL_CONF_RETRY_EN adds one automatic retry on lock timeout.
module pll_conf_ctrl #(
  parameter int SCAN_CYCLES  = 160,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        scan_clk,
  input  logic        scan_rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [8:0]  wr_div,
  input  logic        apply,
  input  logic        pll_locked,
  output logic [17:0] clock_0_conf,
  output logic [17:0] clock_1_conf,
  output logic [17:0] clock_2_conf,
  output logic [17:0] clock_3_conf,
  output logic [17:0] clock_4_conf,
  output logic [17:0] M_config,
  output logic [17:0] N_config,
  output logic        conf_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wr_err
);

  localparam int CNT_MAX = (SCAN_CYCLES > LOCK_TIMEOUT) ? SCAN_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [17:0] RESET_WORD = 18'h2_0000;

  typedef enum logic [2:0] {IDLE, REQ, SCAN_WAIT, LOCK_WAIT, DONE, ERR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_seen_q, lock_seen_d;
  logic               wr_err_q, wr_err_d;
  logic [17:0]        shadow_q [7];
  logic [17:0]        shadow_d [7];
  logic [17:0]        active_q [7];
  logic [17:0]        active_d [7];
  logic               load_active;
  logic               wr_legal;
  logic [17:0]        wr_word;
`ifdef PLL_CONF_RETRY_EN
  logic               retry_q, retry_d;
`endif

  // D=1 is bypass; otherwise high takes the extra count of an odd ratio.
  function automatic logic [17:0] enc_div(input logic [8:0] d);
    if (d == 9'd1) return RESET_WORD;
    return {1'b0, d[0], d[8:1] + {7'd0, d[0]}, d[8:1]};
  endfunction

  assign wr_legal = (wr_div != 9'd0) && (wr_div <= 9'd510) && (wr_addr != 3'd7);
  assign wr_word  = enc_div(wr_div);

  // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    lock_seen_d = 1'b0;
    load_active = 1'b0;
    wr_err_d    = wr_en && !wr_legal;
`ifdef PLL_CONF_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      IDLE: if (apply) begin
        state_d     = REQ;
        load_active = 1'b1;
`ifdef PLL_CONF_RETRY_EN
        retry_d     = 1'b0;
`endif
      end
      REQ: state_d = SCAN_WAIT;
      SCAN_WAIT: begin
        if (cnt_q == SCAN_LAST) state_d = LOCK_WAIT;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      LOCK_WAIT: begin
        lock_seen_d = pll_locked;
        if (pll_locked && lock_seen_q) begin
          state_d = DONE;
        end else if (cnt_q == LOCK_LAST) begin
`ifdef PLL_CONF_RETRY_EN
          if (!retry_q) begin
            state_d = REQ;
            retry_d = 1'b1;
          end else begin
            state_d = ERR;
          end
`else
          state_d = ERR;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      ERR: if (apply) begin
        state_d = REQ;
`ifdef PLL_CONF_RETRY_EN
        retry_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Active words sample the shadow before this cycle's write lands.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && wr_legal && (wr_addr == 3'(i))) shadow_d[i] = wr_word;
      active_d[i] = load_active ? shadow_q[i] : active_q[i];
    end
  end

  // NOTE: the word registers are reset too, since downstream scan logic must never see an undefined divider.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge scan_clk) begin
    if (scan_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lock_seen_q <= 1'b0;
      wr_err_q    <= 1'b0;
      shadow_q    <= '{default: RESET_WORD};
      active_q    <= '{default: RESET_WORD};
`ifdef PLL_CONF_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_seen_q <= lock_seen_d;
      wr_err_q    <= wr_err_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
`ifdef PLL_CONF_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign clock_0_conf = active_q[0];
  assign clock_1_conf = active_q[1];
  assign clock_2_conf = active_q[2];
  assign clock_3_conf = active_q[3];
  assign clock_4_conf = active_q[4];
  assign M_config     = active_q[5];
  assign N_config     = active_q[6];

  assign conf_req = (state_q == REQ);
  assign busy     = (state_q == REQ) || (state_q == SCAN_WAIT) || (state_q == LOCK_WAIT);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_pll_conf_ctrl.sv
// Directed self-checking bench for pll_conf_ctrl (default parameters).
// Inputs change and outputs are sampled on the falling edge of scan_clk.
module tb_pll_conf_ctrl;

  logic        scan_clk = 1'b0;
  logic        scan_rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [8:0]  wr_div = '0;
  logic        apply = 1'b0;
  logic        pll_locked = 1'b0;
  logic [17:0] clock_0_conf, clock_1_conf, clock_2_conf, clock_3_conf, clock_4_conf;
  logic [17:0] M_config, N_config;
  logic        conf_req, busy, done, err, wr_err;
  logic [17:0] conf [7];

  int errors = 0;
  int checks = 0;

  always #5 scan_clk = ~scan_clk;

  pll_conf_ctrl dut (
    .scan_clk(scan_clk), .scan_rst(scan_rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_div(wr_div), .apply(apply), .pll_locked(pll_locked),
    .clock_0_conf(clock_0_conf), .clock_1_conf(clock_1_conf), .clock_2_conf(clock_2_conf),
    .clock_3_conf(clock_3_conf), .clock_4_conf(clock_4_conf),
    .M_config(M_config), .N_config(N_config),
    .conf_req(conf_req), .busy(busy), .done(done), .err(err), .wr_err(wr_err)
  );

  assign conf[0] = clock_0_conf;
  assign conf[1] = clock_1_conf;
  assign conf[2] = clock_2_conf;
  assign conf[3] = clock_3_conf;
  assign conf[4] = clock_4_conf;
  assign conf[5] = M_config;
  assign conf[6] = N_config;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge scan_clk);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = a; wr_div = d;
    @(negedge scan_clk);
    wr_en = 1'b0;
  endtask

  task automatic do_apply();
    apply = 1'b1;
    @(negedge scan_clk);
    apply = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      @(negedge scan_clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic test_reset();
    logic [17:0] exp_rst [7] = '{default: 18'h2_0000};
    scan_rst = 1'b1;
    step(2);
    scan_rst = 1'b0;
    step(1);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (conf[i] !== exp_rst[i]) begin
        errors++;
        $display("FAIL reset_word[%0d]: got %h expected %h", i, conf[i], exp_rst[i]);
      end
    end
    checks++;
    if ({conf_req, busy, done, err, wr_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_status: got %b expected 00000", {conf_req, busy, done, err, wr_err});
    end
  endtask

  task automatic test_writes();
    do_write(3'd0, 9'd5);
    do_write(3'd5, 9'd4);
    do_write(3'd6, 9'd510);
    do_write(3'd1, 9'd3);
    do_write(3'd1, 9'd1);
    do_write(3'd2, 9'd2);
    do_write(3'd3, 9'd255);
    do_write(3'd4, 9'd3);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL legal_no_wr_err: got %b expected 0", wr_err);
    end
    checks++;
    if (clock_0_conf !== 18'h2_0000 || N_config !== 18'h2_0000) begin
      errors++;
      $display("FAIL idle_outputs_hold: got c0=%h N=%h expected 20000", clock_0_conf, N_config);
    end
  endtask

  task automatic test_wr_err();
    logic [8:0] bad_div [3] = '{9'd0, 9'd511, 9'd5};
    logic [2:0] bad_adr [3] = '{3'd0, 3'd6, 3'd7};
    for (int i = 0; i < 3; i++) begin
      do_write(bad_adr[i], bad_div[i]);
      checks++;
      if (wr_err !== 1'b1) begin
        errors++;
        $display("FAIL wr_err_pulse[%0d]: got %b expected 1", i, wr_err);
      end
      step(1);
      checks++;
      if (wr_err !== 1'b0) begin
        errors++;
        $display("FAIL wr_err_clear[%0d]: got %b expected 0", i, wr_err);
      end
    end
  endtask

  task automatic test_apply();
    logic [17:0] exp_w [7] = '{18'h1_0302, 18'h2_0000, 18'h0_0101, 18'h1_807F,
                               18'h1_0201, 18'h0_0202, 18'h0_FFFF};
    apply = 1'b1;
    step(0);
    checks++;
    if (clock_0_conf !== 18'h2_0000 || conf_req !== 1'b0) begin
      errors++;
      $display("FAIL pre_apply: got c0=%h req=%b expected 20000/0", clock_0_conf, conf_req);
    end
    @(negedge scan_clk);
    apply = 1'b0;
    checks++;
    if (conf_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL req_cycle: got req=%b busy=%b expected 1/1", conf_req, busy);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (conf[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL applied_word[%0d]: got %h expected %h", i, conf[i], exp_w[i]);
      end
    end
  endtask

  // Entered while observing the REQ cycle (cycle 0).
  task automatic test_lock();
    int done_at = -1, done_cnt = 0, req_cnt = 0;
    logic busy_172 = 1'b0, busy_174 = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (conf_req === 1'b1) req_cnt++;
      if (k == 172) busy_172 = busy;
      if (k == 174) busy_174 = busy;
      if (k == 171) pll_locked = 1'b1;
      @(negedge scan_clk);
    end
    checks++;
    if (done_at != 173) begin
      errors++;
      $display("FAIL done_cycle: got %0d expected 173", done_at);
    end
    checks++;
    if (done_cnt != 1 || req_cnt != 1) begin
      errors++;
      $display("FAIL done_once: got done=%0d req=%0d expected 1/1", done_cnt, req_cnt);
    end
    checks++;
    if (busy_172 !== 1'b1 || busy_174 !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got %b%b expected 10", busy_172, busy_174);
    end
  endtask

  task automatic test_scan_write();
    pll_locked = 1'b1;
    do_apply();
    step(5);
    do_write(3'd2, 9'd7);
    step(3);
    checks++;
    if (clock_2_conf !== 18'h0_0101 || busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_write_hold: got c2=%h busy=%b expected 00101/1", clock_2_conf, busy);
    end
    wait_done(400);
    checks++;
    if (clock_2_conf !== 18'h0_0101) begin
      errors++;
      $display("FAIL done_word_hold: got %h expected 00101", clock_2_conf);
    end
    step(1);
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 3'd3; wr_div = 9'd9; apply = 1'b1;
    @(negedge scan_clk);
    wr_en = 1'b0; apply = 1'b0;
    checks++;
    if (clock_3_conf !== 18'h1_807F || clock_2_conf !== 18'h1_0403 || conf_req !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_apply: got c3=%h c2=%h req=%b expected 1807f/10403/1",
               clock_3_conf, clock_2_conf, conf_req);
    end
    wait_done(400);
    step(1);
    do_apply();
    checks++;
    if (clock_3_conf !== 18'h1_0504) begin
      errors++;
      $display("FAIL shadow_after_same_cycle: got %h expected 10504", clock_3_conf);
    end
    pll_locked = 1'b0;
  endtask

  // Entered in the REQ cycle of an apply with pll_locked low.
  task automatic test_reset_mid();
    int req_cnt = 0, busy_cnt = 0;
    step(170);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_wait_busy: got %b expected 1", busy);
    end
    scan_rst = 1'b1;
    step(1);
    scan_rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (conf[i] !== 18'h2_0000) begin
        errors++;
        $display("FAIL mid_reset_word[%0d]: got %h expected 20000", i, conf[i]);
      end
    end
    for (int k = 0; k < 300; k++) begin
      if (conf_req === 1'b1) req_cnt++;
      if (busy === 1'b1) busy_cnt++;
      @(negedge scan_clk);
    end
    checks++;
    if (req_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got req=%0d busy=%0d expected 0/0", req_cnt, busy_cnt);
    end
  endtask

  task automatic test_timeout();
    int err_at = -1, req_cnt = 0;
`ifdef PLL_CONF_RETRY_EN
    int exp_at = 2 * (1 + 160 + 4096), exp_req = 2;
`else
    int exp_at = 1 + 160 + 4096, exp_req = 1;
`endif
    pll_locked = 1'b0;
    do_write(3'd0, 9'd5);
    do_apply();
    for (int k = 0; k < 9000; k++) begin
      if (conf_req === 1'b1) req_cnt++;
      if (err === 1'b1) begin
        err_at = k;
        break;
      end
      @(negedge scan_clk);
    end
    checks++;
    if (err_at != exp_at || req_cnt != exp_req) begin
      errors++;
      $display("FAIL timeout_err: got cycle=%0d req=%0d expected %0d/%0d",
               err_at, req_cnt, exp_at, exp_req);
    end
    step(3);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_hold: got err=%b busy=%b expected 1/0", err, busy);
    end
    do_apply();
    checks++;
    if (err !== 1'b0 || conf_req !== 1'b1) begin
      errors++;
      $display("FAIL err_apply: got err=%b req=%b expected 0/1", err, conf_req);
    end
  endtask

  initial begin
    step(1);
    test_reset();
    test_writes();
    test_wr_err();
    test_apply();
    test_lock();
    test_scan_write();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
